// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
// Holds the data width and the hazard-controller state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN      = ST_RUN,
        S_DRAIN    = ST_DRAIN,
        S_REDIRECT = ST_REDIRECT
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// The counter stops at all-ones and never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / redirect controller for the 5-stage RV32I pipeline.
// Resolves load-use, taken branches, memory waits and ecall trap sequencing.
module pipe_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_ecall,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_re,
    input  logic             ex_br_taken,
    input  logic [XLEN-1:0]  ex_br_target,
    input  logic [XLEN-1:0]  csr_mtvec,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             trap_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e     state;
    logic [3:0] drain_cnt;

    logic br_taken;
    logic ecall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic unused_mtvec_lsb;

    assign br_taken = ex_valid & ex_br_taken;
    assign ecall    = id_valid & id_ecall;
    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use = id_valid & ex_valid & ex_mem_re
                    & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    assign unused_mtvec_lsb = ^csr_mtvec[1:0];

    // Async reset clears state at once, so trap_busy drops with rst.
    assign trap_busy = (state != S_RUN);

    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        pipe_freeze    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (br_taken) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_br_target;
                        if_id_flush    = 1'b1;
                        id_ex_bubble   = 1'b1;
                    end else if (ecall) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                S_REDIRECT: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_mtvec[XLEN-1:2], 2'b00};
                    if_id_flush    = 1'b1;
                    id_ex_bubble   = 1'b1;
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            drain_cnt <= 4'd0;
        end else if (!mem_busy) begin
            case (state)
                S_RUN: begin
                    if (!br_taken && ecall) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 4'(DRAIN_CYCLES);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt - 4'd1;
                    if (drain_cnt == 4'd1) begin
                        state <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_stall),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if_id_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
// Each scenario task pushes expected outputs and checks them the same cycle.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_ecall;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_valid, ex_mem_re, ex_br_taken, mem_busy;
    logic [31:0] ex_br_target, csr_mtvec;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic        pipe_freeze, redirect_valid, trap_busy;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic        rst;
        logic        id_valid;
        logic [4:0]  id_rs1;
        logic [4:0]  id_rs2;
        logic        use1;
        logic        use2;
        logic        ecall;
        logic        ex_valid;
        logic [4:0]  ex_rd;
        logic        mem_re;
        logic        br;
        logic [31:0] target;
        logic [31:0] mtvec;
        logic        busy;
    } in_t;

    typedef struct packed {
        logic        rst_on;
        logic        ps;
        logic        iis;
        logic        iif;
        logic        bub;
        logic        frz;
        logic        rv;
        logic [31:0] pc;
        logic        tb;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [15:0] m_stall = 16'd0;
    logic [15:0] m_flush = 16'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .XLEN(32), .DRAIN_CYCLES(3), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ecall(id_ecall), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_mem_re(ex_mem_re), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .csr_mtvec(csr_mtvec),
        .mem_busy(mem_busy), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_busy(trap_busy), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    function automatic in_t idle();
        in_t i;
        i = '0;
        i.mtvec = 32'h0000_2003;
        return i;
    endfunction

    function automatic exp_t mk(input logic ps, input logic iis,
                                input logic iif, input logic bub,
                                input logic frz, input logic rv,
                                input logic [31:0] pc, input logic tb);
        exp_t e;
        e = '0;
        e.ps = ps; e.iis = iis; e.iif = iif; e.bub = bub;
        e.frz = frz; e.rv = rv; e.pc = pc; e.tb = tb;
        return e;
    endfunction

    // One clock cycle: drive, enqueue expectation, dequeue and compare.
    task automatic apply(input in_t i, input exp_t e, input string tag);
        exp_t        x;
        logic [15:0] es, ef;
        @(posedge clk);
        #1;
        rst = i.rst; id_valid = i.id_valid;
        id_rs1 = i.id_rs1; id_rs2 = i.id_rs2;
        id_use_rs1 = i.use1; id_use_rs2 = i.use2;
        id_ecall = i.ecall; ex_valid = i.ex_valid; ex_rd = i.ex_rd;
        ex_mem_re = i.mem_re; ex_br_taken = i.br;
        ex_br_target = i.target; csr_mtvec = i.mtvec; mem_busy = i.busy;
        e.rst_on = i.rst;
        sb.push_back(e);
        #3;
        x  = sb.pop_front();
        es = x.rst_on ? 16'd0 : m_stall;
        ef = x.rst_on ? 16'd0 : m_flush;
        checks++;
        if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze,
             redirect_valid, redirect_pc, trap_busy, stall_cnt, flush_cnt}
            !== {x.ps, x.iis, x.iif, x.bub, x.frz, x.rv, x.pc, x.tb, es, ef})
            $display("FAIL %s: got ps=%b iis=%b iif=%b bub=%b frz=%b rv=%b pc=%h tb=%b sc=%0d fc=%0d, want ps=%b iis=%b iif=%b bub=%b frz=%b rv=%b pc=%h tb=%b sc=%0d fc=%0d",
                     tag, pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                     pipe_freeze, redirect_valid, redirect_pc, trap_busy,
                     stall_cnt, flush_cnt, x.ps, x.iis, x.iif, x.bub, x.frz,
                     x.rv, x.pc, x.tb, es, ef);
        else
            passes++;
        if (x.rst_on) begin
            m_stall = 16'd0;
            m_flush = 16'd0;
        end else begin
            if (x.ps && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (x.iif && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
    endtask

    task automatic test_reset();
        in_t i;
        i = idle();
        i.rst = 1'b1; i.busy = 1'b1; i.br = 1'b1; i.ex_valid = 1'b1;
        i.target = 32'h40;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "reset_gate");
        i = idle();
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "reset_idle");
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0",
                     stall_cnt, flush_cnt);
        else
            passes++;
    endtask

    task automatic test_load_use();
        in_t i;
        i = idle();
        i.id_valid = 1; i.ex_valid = 1; i.mem_re = 1; i.ex_rd = 5'd5;
        i.use2 = 1; i.id_rs2 = 5'd5; i.id_rs1 = 5'd7; i.use1 = 1;
        apply(i, mk(1, 1, 0, 1, 0, 0, 32'h0, 0), "lu_rs2");
        i.ex_rd = 5'd0; i.id_rs2 = 5'd0;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "lu_x0");
        checks++;
        if (stall_cnt !== 16'd1)
            $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
        else
            passes++;
        i.ex_rd = 5'd7;
        apply(i, mk(1, 1, 0, 1, 0, 0, 32'h0, 0), "lu_rs1");
        i.use1 = 0;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "lu_nouse");
        i.use1 = 1; i.mem_re = 0;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "lu_noload");
    endtask

    task automatic test_branch();
        in_t i;
        i = idle();
        i.ex_valid = 1; i.br = 1; i.target = 32'h0000_0100;
        i.id_valid = 1; i.ecall = 1;
        i.mem_re = 1; i.ex_rd = 5'd3; i.use1 = 1; i.id_rs1 = 5'd3;
        apply(i, mk(0, 0, 1, 1, 0, 1, 32'h100, 0), "br_taken");
        i = idle();
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "br_after");
        checks++;
        if (flush_cnt !== 16'd1)
            $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt);
        else
            passes++;
        i.br = 1; i.target = 32'h200;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "br_ex_invalid");
    endtask

    task automatic test_ecall();
        in_t i;
        i = idle();
        i.id_valid = 1; i.ecall = 1;
        apply(i, mk(1, 0, 1, 0, 0, 0, 32'h0, 0), "ec_issue");
        i = idle();
        i.ex_valid = 1; i.br = 1; i.target = 32'h300;
        for (int k = 0; k < 3; k++)
            apply(i, mk(1, 1, 0, 1, 0, 0, 32'h0, 1), "ec_drain");
        i = idle();
        apply(i, mk(0, 0, 1, 1, 0, 1, 32'h2000, 1), "ec_redirect");
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "ec_run");
    endtask

    task automatic test_freeze_drain();
        in_t i;
        i = idle();
        i.id_valid = 1; i.ecall = 1; i.mtvec = 32'h0000_8001;
        apply(i, mk(1, 0, 1, 0, 0, 0, 32'h0, 0), "fz_issue");
        i = idle(); i.mtvec = 32'h0000_8001;
        apply(i, mk(1, 1, 0, 1, 0, 0, 32'h0, 1), "fz_drain3");
        i.busy = 1;
        for (int k = 0; k < 2; k++)
            apply(i, mk(1, 1, 0, 0, 1, 0, 32'h0, 1), "fz_frozen");
        i.busy = 0;
        for (int k = 0; k < 2; k++)
            apply(i, mk(1, 1, 0, 1, 0, 0, 32'h0, 1), "fz_drain");
        i.busy = 1;
        apply(i, mk(1, 1, 0, 0, 1, 0, 32'h0, 1), "fz_hold_redir");
        i.busy = 0;
        apply(i, mk(0, 0, 1, 1, 0, 1, 32'h8000, 1), "fz_redirect");
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "fz_run");
    endtask

    task automatic test_reset_mid();
        in_t i;
        i = idle();
        i.id_valid = 1; i.ecall = 1;
        apply(i, mk(1, 0, 1, 0, 0, 0, 32'h0, 0), "rm_issue");
        i = idle();
        apply(i, mk(1, 1, 0, 1, 0, 0, 32'h0, 1), "rm_drain");
        i.rst = 1;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "rm_reset");
        checks++;
        if (stall_cnt !== 16'd0 || trap_busy !== 1'b0)
            $display("FAIL rm_state: got cnt=%0d busy=%b want 0/0",
                     stall_cnt, trap_busy);
        else
            passes++;
        i.rst = 0;
        for (int k = 0; k < 4; k++)
            apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "rm_no_redirect");
    endtask

    task automatic test_saturation();
        in_t i;
        i = idle();
        i.busy = 1;
        for (int k = 0; k < 65535; k++)
            apply(i, mk(1, 1, 0, 0, 1, 0, 32'h0, 0), "sat_fill");
        i.busy = 0;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "sat_idle");
        checks++;
        if (stall_cnt !== 16'hFFFF)
            $display("FAIL sat_full: got %h want ffff", stall_cnt);
        else
            passes++;
        i.busy = 1;
        apply(i, mk(1, 1, 0, 0, 1, 0, 32'h0, 0), "sat_extra");
        i.busy = 0;
        apply(i, mk(0, 0, 0, 0, 0, 0, 32'h0, 0), "sat_idle2");
        checks++;
        if (stall_cnt !== 16'hFFFF)
            $display("FAIL sat_hold: got %h want ffff", stall_cnt);
        else
            passes++;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0;
        id_use_rs2 = 0; id_ecall = 0; ex_valid = 0; ex_rd = 0;
        ex_mem_re = 0; ex_br_taken = 0; ex_br_target = 0;
        csr_mtvec = 0; mem_busy = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_ecall();
        test_freeze_drain();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
